// File: rtl/packet_injector.sv
// Packet injector: turns a descriptor plus payload stream into HEAD/BODY/TAIL flits
// on a free downstream VC, honouring per-VC on/off flow control.
package packet_injector_pkg;
  localparam int unsigned VC_NUM            = 2;
  localparam int unsigned VC_W              = $clog2(VC_NUM);
  localparam int unsigned DEST_ADDR_SIZE_X  = 4;
  localparam int unsigned DEST_ADDR_SIZE_Y  = 4;
  localparam int unsigned FLIT_DATA_SIZE    = 16;
  localparam int unsigned HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;
  localparam int unsigned MAX_PKT_FLITS     = 8;
  localparam int unsigned LEN_W             = $clog2(MAX_PKT_FLITS + 1);

  typedef enum logic [1:0] {
    HEAD     = 2'd0,
    BODY     = 2'd1,
    TAIL     = 2'd2,
    HEADTAIL = 2'd3
  } flit_label_t;

  typedef struct packed {
    logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
    logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
    logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
  } head_data_t;

  typedef union packed {
    head_data_t                head;
    logic [FLIT_DATA_SIZE-1:0] bt_pl;
  } flit_data_t;

  typedef struct packed {
    flit_label_t     flit_label;
    logic [VC_W-1:0] vc_id;
    flit_data_t      data;
  } flit_t;
endpackage

module packet_injector
  import packet_injector_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pkt_valid_i,
  output logic                         pkt_ready_o,
  input  logic [DEST_ADDR_SIZE_X-1:0]  pkt_x_dest_i,
  input  logic [DEST_ADDR_SIZE_Y-1:0]  pkt_y_dest_i,
  input  logic [HEAD_PAYLOAD_SIZE-1:0] pkt_head_pl_i,
  input  logic [LEN_W-1:0]             pkt_len_i,
  input  logic                         pl_valid_i,
  output logic                         pl_ready_o,
  input  logic [FLIT_DATA_SIZE-1:0]    pl_data_i,
  output flit_t                        data_o,
  output logic                         is_valid_o,
  input  logic [VC_NUM-1:0]            is_on_off_i,
  input  logic [VC_NUM-1:0]            is_allocatable_i,
  output logic                         pkt_done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t                       r_state,     w_state_nxt;
  logic [DEST_ADDR_SIZE_X-1:0]  r_x,         w_x_nxt;
  logic [DEST_ADDR_SIZE_Y-1:0]  r_y,         w_y_nxt;
  logic [HEAD_PAYLOAD_SIZE-1:0] r_hpl,       w_hpl_nxt;
  logic [LEN_W-1:0]             r_len,       w_len_nxt;
  logic [LEN_W-1:0]             r_rem,       w_rem_nxt;
  logic [VC_W-1:0]              r_vc,        w_vc_nxt;
  flit_t                        r_data,      w_data_nxt;
  logic                         r_valid,     w_valid_nxt;
  logic                         r_done,      w_done_nxt;
  logic                         r_pkt_ready;
  logic                         w_pl_ready;
  logic [VC_NUM-1:0]            w_elig;
  logic [VC_W-1:0]              w_sel;

  // Lowest-index VC that is both allocatable and on
  always_comb begin
    w_elig = is_allocatable_i & is_on_off_i;
    w_sel  = '0;
    for (int v = int'(VC_NUM) - 1; v >= 0; v--) begin
      if (w_elig[v]) w_sel = VC_W'(v);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_hpl_nxt   = r_hpl;
    w_len_nxt   = r_len;
    w_rem_nxt   = r_rem;
    w_vc_nxt    = r_vc;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_pl_ready  = 1'b0;
    case (r_state)
      IDLE: begin
        if (pkt_valid_i && r_pkt_ready) begin
          w_x_nxt   = pkt_x_dest_i;
          w_y_nxt   = pkt_y_dest_i;
          w_hpl_nxt = pkt_head_pl_i;
          if (pkt_len_i == '0)
            w_len_nxt = LEN_W'(1);
          else if (pkt_len_i > LEN_W'(MAX_PKT_FLITS))
            w_len_nxt = LEN_W'(MAX_PKT_FLITS);
          else
            w_len_nxt = pkt_len_i;
          w_state_nxt = ALLOC;
        end
      end
      ALLOC: begin
        if (|w_elig) begin
          w_vc_nxt                    = w_sel;
          w_data_nxt.vc_id            = w_sel;
          w_data_nxt.data.head.x_dest  = r_x;
          w_data_nxt.data.head.y_dest  = r_y;
          w_data_nxt.data.head.head_pl = r_hpl;
          w_valid_nxt                 = 1'b1;
          if (r_len == LEN_W'(1)) begin
            w_data_nxt.flit_label = HEADTAIL;
            w_done_nxt            = 1'b1;
            w_state_nxt           = IDLE;
          end else begin
            w_data_nxt.flit_label = HEAD;
            w_rem_nxt             = r_len - LEN_W'(1);
            w_state_nxt           = SEND;
          end
        end
      end
      SEND: begin
        w_pl_ready = is_on_off_i[r_vc];
        if (pl_valid_i && w_pl_ready) begin
          w_data_nxt.vc_id      = r_vc;
          w_data_nxt.data.bt_pl = pl_data_i;
          w_valid_nxt           = 1'b1;
          w_rem_nxt             = r_rem - LEN_W'(1);
          if (r_rem == LEN_W'(1)) begin
            w_data_nxt.flit_label = TAIL;
            w_done_nxt            = 1'b1;
            w_state_nxt           = IDLE;
          end else begin
            w_data_nxt.flit_label = BODY;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_hpl       <= '0;
      r_len       <= '0;
      r_rem       <= '0;
      r_vc        <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_pkt_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_hpl       <= w_hpl_nxt;
      r_len       <= w_len_nxt;
      r_rem       <= w_rem_nxt;
      r_vc        <= w_vc_nxt;
      r_data      <= w_data_nxt;
      r_valid     <= w_valid_nxt;
      r_done      <= w_done_nxt;
      r_pkt_ready <= (w_state_nxt == IDLE);
    end
  end

  assign pkt_ready_o = r_pkt_ready;
  assign pl_ready_o  = w_pl_ready;
  assign data_o      = r_data;
  assign is_valid_o  = r_valid;
  assign pkt_done_o  = r_done;

endmodule

// File: doc/packet_injector.md
# packet_injector

Node-side transmitter that injects packets into a router's local input port over the router-to-router link. It accepts a packet descriptor (destination and length) plus a stream of payload words. It selects a free downstream virtual channel and emits HEAD/BODY/TAIL (or HEADTAIL) flits. Flit emission obeys the per-VC on/off flow control and the VC-allocatable status returned by the router.

## Interface
- MAX_PKT_FLITS, 8: maximum flits per packet; lengths above this are clamped.
- LEN_W, $clog2(MAX_PKT_FLITS+1): width of the length field.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low.
- pkt_valid_i  input  1  descriptor valid.
- pkt_ready_o  output  1  descriptor accepted when valid&ready.
- pkt_x_dest_i  input  DEST_ADDR_SIZE_X  destination X.
- pkt_y_dest_i  input  DEST_ADDR_SIZE_Y  destination Y.
- pkt_head_pl_i  input  HEAD_PAYLOAD_SIZE  head-flit payload.
- pkt_len_i  input  LEN_W  total flits including head; 0 is treated as 1.
- pl_valid_i  input  1  body/tail payload word valid.
- pl_ready_o  output  1  payload word consumed when valid&ready.
- pl_data_i  input  FLIT_DATA_SIZE  body/tail payload.
- data_o  output  flit_t  flit to router (flit_label, vc_id, head: x_dest/y_dest/head_pl, body/tail: bt_pl).
- is_valid_o  output  1  data_o carries a flit this cycle.
- is_on_off_i  input  VC_NUM  per-VC on/off from router; 1 = may send.
- is_allocatable_i  input  VC_NUM  per-VC idle/allocatable from router.
- pkt_done_o  output  1  one-cycle pulse, registered with the last flit's is_valid_o.

## Operation
- Three states: IDLE, ALLOC, SEND.
- IDLE:
  - pkt_ready_o=1.
  - On accept, capture dest, head_pl and len (0→1, >MAX→MAX); go to ALLOC.
- ALLOC:
  - pkt_ready_o=0.
  - vc_sel is the lowest index v with is_allocatable_i[v] & is_on_off_i[v].
  - If none exists, stay in ALLOC with no flit.
  - If one exists, register a head flit with vc_id=v and lock v for the packet.
  - Label is HEADTAIL if len==1, then go to IDLE. Otherwise label is HEAD, set remaining=len-1 and go to SEND.
- SEND:
  - pl_ready_o = is_on_off_i[locked_vc].
  - On payload handshake, register a flit with bt_pl=pl_data_i and vc_id=locked_vc, then decrement remaining.
  - Label is TAIL when remaining==1, then go to IDLE. Otherwise label is BODY.
- pl_ready_o=0 outside SEND. Payload words presented early are held, not dropped.
- is_valid_o is a register, cleared in every cycle in which no flit was issued on the preceding edge.
- data_o holds its last value when is_valid_o=0; its content is don't-care then.
- The locked VC never changes mid-packet, even if is_allocatable_i drops, because the router clears it once allocated.

## Timing
- Reset (rst=0, asynchronous) clears everything:
  - state=IDLE
  - is_valid_o=0
  - pkt_done_o=0
  - pl_ready_o=0
  - pkt_ready_o=1 once rst deasserts; 0 while rst=0
  - data_o=0
  - remaining=0
- Reset mid-packet discards the packet with no tail. The router is reset alongside, so this is legal.
- Accept at edge k gives ALLOC during cycle k+1. With a VC available, the head is visible (is_valid_o=1) in cycle k+2.
- A body/tail handshake in cycle n gives the flit valid in cycle n+1.
- Peak throughput is one flit per cycle in SEND.
- On/off is sampled in the cycle the flit is committed. The router's on/off threshold absorbs the one-cycle in-flight flit.
- is_on_off_i[locked_vc]=0 stalls SEND, and no payload is consumed. Other VCs' on/off are ignored.
- The tail edge returns to IDLE, so a new descriptor can be accepted the next cycle. The minimum gap between packets is 1 idle flit cycle (ALLOC).
- If several VCs are eligible simultaneously, the lowest index wins. There is no rotation.
- Mid-packet, pkt_valid_i changes are ignored (pkt_ready_o=0).

## Test plan
- Reset, then descriptor len=1, dest (2,3), all VCs allocatable/on → single HEADTAIL flit, vc_id=0, x_dest=2, y_dest=3, valid exactly in cycle k+2; pkt_done_o pulses with it.
- len=4, payloads 0xA,0xB,0xC presented every cycle → HEAD, BODY 0xA, BODY 0xB, TAIL 0xC on consecutive cycles, all same vc_id.
- is_allocatable_i=2'b01 with is_on_off_i=2'b10, then is_allocatable_i → 2'b11 → ALLOC waits while no VC is both allocatable and on, then selects VC1 when is_allocatable_i goes to 2'b11.
- Mid-packet, drop is_on_off_i[locked] for 3 cycles → no valid flits and pl_ready_o=0 for those cycles; resumes with the next word, nothing lost or duplicated.
- pkt_len_i=0 → HEADTAIL; pkt_len_i=15 with MAX=8 → exactly 8 flits.
- Assert rst during a BODY flit → is_valid_o=0 immediately; after release, a new len=2 packet is sent correctly starting with HEAD.
